photo_binarizer_buffer: RTL
===========================

// Module: photo_binarizer_buffer
// PURPOSE
//   Parametrised camera-to-bitmap stage: thresholds a live RGB565 pixel stream into a
//   1-bit image (1 = black/selected), captures one full frame window of IMG_W x IMG_H,
//   then replays it row by row under valid/ready handshake to the downscale filter.
//   Replaces the ad-hoc digi_photo array; adds colour modes, frame sync and backpressure.
// PARAMETERS
//   SRC_W   320  valid pixels per source line (column counter wrap)
//   SRC_H   240  source lines per frame
//   IMG_W   320  captured columns (IMG_W <= SRC_W), leftmost columns kept
//   IMG_H   240  captured rows (IMG_H <= SRC_H), topmost rows kept
// PORTS
//   clk_in          in   1       system clock; all logic on posedge
//   reset_n_in      in   1       asynchronous active-low reset
//   pixel_in        in   16      RGB565; r=[15:12] g=[10:7] b=[4:1]
//   pixel_valid_in  in   1       pixel_in valid this cycle
//   frame_done_in   in   1       one-cycle end-of-frame pulse
//   mode_in         in   2       0 luma, 1 red, 2 green, 3 blue; sampled on arm
//   thresh_in       in   6       luma threshold; sampled on arm
//   arm_in          in   1       request a new capture (IDLE or READY)
//   start_in        in   1       request row replay (READY only)
//   ready_in        in   1       consumer accepts row this cycle
//   row_out         out  IMG_W   bit[x] = pixel column x of current row
//   row_valid_out   out  1       row_out/row_idx_out valid
//   row_idx_out     out  $clog2(IMG_H)  row number 0..IMG_H-1
//   row_last_out    out  1       high with row IMG_H-1
//   done_out        out  1       one-cycle pulse after last row accepted
//   busy_out        out  1       state is SYNC, CAPTURE or STREAM
//   captured_out    out  1       a complete image is held
//   overrun_out     out  1       sticky: frame ended short; cleared on arm
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; counters 0; stored image contents undefined.
//   Classify (combinational on pixel_in, 4-bit fields):
//     luma = (r>>2)+(g>>1)+(b>>2), 6-bit; bit = (luma <= thresh)
//     red: r>8 && g<8 && b<8; green: g>8 && r<8 && b<8; blue: b>8 && r<8 && g<8
//   States:
//     IDLE    arm_in -> SYNC; latch mode/thresh; clear overrun_out, captured_out.
//     SYNC    discard pixels; frame_done_in -> CAPTURE with x=y=0.
//     CAPTURE each pixel_valid_in: if x<IMG_W set shift bit x; x++.
//             x==SRC_W-1 on valid: x=0; if y<IMG_H write row y to RAM; y++.
//             y==SRC_H-1 and x==SRC_W-1 on valid: -> READY, captured_out=1.
//             frame_done_in before that: overrun_out=1, -> CAPTURE restart x=y=0.
//             frame_done_in same cycle as final pixel: counts as complete.
//     READY   start_in -> STREAM, r=0. arm_in -> SYNC (arm wins over start).
//     STREAM  row r presented; row_valid_out held until ready_in; on handshake r++.
//             handshake on r==IMG_H-1 -> done_out pulse next cycle, -> READY.
//             arm_in and pixels ignored while streaming.
//   Latency: start_in to first row_valid_out = 2 cycles (RAM read); output stable
//   while valid && !ready; next row valid the cycle after handshake under constant
//   ready (one row per cycle sustained after first).
//   Row RAM: IMG_H x IMG_W, one write port (capture), one read port (stream);
//   image survives any number of replays until next arm.
//   reset_n_in low at any point: immediate return to IDLE, outputs cleared.
// TESTING
//   4x3 image, SRC 4x3, luma mode thresh=5: pixels alternate 0xFFFF/0x0000 ->
//     rows read 4'b1010 each, row_last on row 2, done_out one pulse.
//   Red mode, pixel 0xF800 vs 0xFFFF -> bit 1 for 0xF800, 0 for white.
//   frame_done_in after 5 of 12 pixels -> overrun_out=1, captured_out stays 0;
//     next full frame -> captured_out=1, overrun_out remains 1 until re-arm.
//   ready_in toggled 1,0,0,1 during STREAM -> row_out/row_idx_out held, no row skipped.
//   SRC 6x4, IMG 4x3 -> columns 4-5 and row 3 dropped; stored rows match cols 0-3.
//   reset_n_in asserted mid-STREAM -> row_valid_out=0 same cycle; start_in ignored until re-capture.

Source files
------------

// File: rtl/photo_binarizer_buffer.sv
// Camera-to-bitmap stage: thresholds an RGB565 stream into a 1-bit image, captures one
// IMG_W x IMG_H window per armed frame and replays it row by row under valid/ready.
module photo_binarizer_buffer #(
    parameter int SRC_W = 320,
    parameter int SRC_H = 240,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic [15:0]              pixel_in,
    input  logic                     pixel_valid_in,
    input  logic                     frame_done_in,
    input  logic [1:0]               mode_in,
    input  logic [5:0]               thresh_in,
    input  logic                     arm_in,
    input  logic                     start_in,
    input  logic                     ready_in,
    output logic [IMG_W-1:0]         row_out,
    output logic                     row_valid_out,
    output logic [$clog2(IMG_H)-1:0] row_idx_out,
    output logic                     row_last_out,
    output logic                     done_out,
    output logic                     busy_out,
    output logic                     captured_out,
    output logic                     overrun_out
);

    localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int RW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(SRC_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SRC_H - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_CAPTURE, S_READY, S_STREAM} state_t;

    state_t           state;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [RW-1:0]    r;
    logic [1:0]       mode_q;
    logic [5:0]       thr_q;
    logic [IMG_W-1:0] row_buf;
    logic [IMG_W-1:0] row_next;
    logic [IMG_W-1:0] mem [IMG_H];

    logic [3:0] px_r, px_g, px_b;
    logic [5:0] luma;
    logic       pix_bit;
    logic       at_last, cap_px, arm_ok, y_in_img;
    logic       unused_bits;

    assign px_r        = pixel_in[15:12];
    assign px_g        = pixel_in[10:7];
    assign px_b        = pixel_in[4:1];
    assign unused_bits = ^{pixel_in[11], pixel_in[6:5], pixel_in[0]};

    always_comb begin
        luma    = {4'b0, px_r[3:2]} + {3'b0, px_g[3:1]} + {4'b0, px_b[3:2]};
        pix_bit = 1'b0;
        case (mode_q)
            2'd0: pix_bit = (luma <= thr_q);
            2'd1: pix_bit = (px_r > 4'd8) && (px_g < 4'd8) && (px_b < 4'd8);
            2'd2: pix_bit = (px_g > 4'd8) && (px_r < 4'd8) && (px_b < 4'd8);
            default: pix_bit = (px_b > 4'd8) && (px_r < 4'd8) && (px_g < 4'd8);
        endcase
    end

    // Current pixel merged into the row so the row-end write includes it.
    always_comb begin
        row_next = row_buf;
        for (int unsigned i = 0; i < IMG_W; i++) begin
            if (32'(x) == i) row_next[i] = pix_bit;
        end
    end

    assign at_last  = (x == X_LAST) && (y == Y_LAST);
    assign cap_px   = (state == S_CAPTURE) && pixel_valid_in && (at_last || !frame_done_in);
    assign arm_ok   = arm_in && ((state == S_IDLE) || (state == S_READY));
    assign y_in_img = (32'(y) < 32'(IMG_H));
    assign busy_out = (state == S_SYNC) || (state == S_CAPTURE) || (state == S_STREAM);

    always_ff @(posedge clk_in) begin
        if (cap_px && (x == X_LAST) && y_in_img) mem[y[RW-1:0]] <= row_next;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state         <= S_IDLE;
            x             <= '0;
            y             <= '0;
            r             <= '0;
            mode_q        <= '0;
            thr_q         <= '0;
            row_buf       <= '0;
            row_out       <= '0;
            row_valid_out <= 1'b0;
            row_idx_out   <= '0;
            row_last_out  <= 1'b0;
            done_out      <= 1'b0;
            captured_out  <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (arm_ok) begin
                state        <= S_SYNC;
                mode_q       <= mode_in;
                thr_q        <= thresh_in;
                overrun_out  <= 1'b0;
                captured_out <= 1'b0;
            end else begin
                case (state)
                    S_SYNC: begin
                        if (frame_done_in) begin
                            state <= S_CAPTURE;
                            x     <= '0;
                            y     <= '0;
                        end
                    end
                    S_CAPTURE: begin
                        if (cap_px) begin
                            row_buf <= row_next;
                            if (at_last) begin
                                state        <= S_READY;
                                captured_out <= 1'b1;
                                x            <= '0;
                                y            <= '0;
                            end else if (x == X_LAST) begin
                                x <= '0;
                                y <= y + 1'b1;
                            end else begin
                                x <= x + 1'b1;
                            end
                        end else if (frame_done_in) begin
                            overrun_out <= 1'b1;
                            x           <= '0;
                            y           <= '0;
                        end
                    end
                    S_READY: begin
                        if (start_in) begin
                            state <= S_STREAM;
                            r     <= '0;
                        end
                    end
                    S_STREAM: begin
                        // Next row is fetched on the handshake edge to sustain one row per cycle.
                        if (!row_valid_out) begin
                            row_out       <= mem[r];
                            row_idx_out   <= r;
                            row_last_out  <= (r == R_LAST);
                            row_valid_out <= 1'b1;
                        end else if (ready_in) begin
                            if (r == R_LAST) begin
                                row_valid_out <= 1'b0;
                                row_last_out  <= 1'b0;
                                done_out      <= 1'b1;
                                state         <= S_READY;
                            end else begin
                                r            <= r + 1'b1;
                                row_out      <= mem[r + 1'b1];
                                row_idx_out  <= r + 1'b1;
                                row_last_out <= ((r + 1'b1) == R_LAST);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
